display_arbiter: RTL

Shares the 4-digit seven-segment display between four 16-bit requesters, such as pipeline stage probes for PC, instruction, ALU result and writeback data. Each requester raises a request and holds its word. The block accepts requests in round-robin order, latches the granted word and keeps it on screen for a minimum dwell time. An optional pin mode locks the display to one source. `disp_data` drives the `binary_data` input of the display driver.

---
 rtl/display_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// Round-robin share of the 7-seg display among four 16-bit sources; req->ack latency 1 cycle.
// No backpressure: requesters hold req/data until ack, captured word dwells DWELL cycles (pin mode bypasses).
module display_arbiter #(
  parameter int DWELL = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [63:0] src_data,
  input  logic        pin_en,
  input  logic [1:0]  pin_sel,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic [15:0] disp_data,
  output logic        disp_valid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ptr;

  logic             win_vld;
  logic [1:0]       win_id;
  logic [1:0]       idx;
  logic [15:0]      win_dat;

  // Scan ptr+1 .. ptr+4 (mod 4) so the last winner has lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    idx     = 2'd0;
    if (pin_en) begin
      win_vld = req[pin_sel];
      win_id  = pin_sel;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = ptr + 2'(k);
        if (!win_vld && req[idx]) begin
          win_vld = 1'b1;
          win_id  = idx;
        end
      end
    end
  end

  assign win_dat = src_data[{win_id, 4'b0000} +: 16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= 2'd3;
      grant_id   <= 2'd0;
      disp_data  <= 16'h0000;
      disp_valid <= 1'b0;
      ack        <= 4'b0000;
    end else begin
      ack <= 4'b0000;
      case (state)
        IDLE: begin
          if (win_vld) begin
            disp_data  <= win_dat;
            grant_id   <= win_id;
            ptr        <= win_id;
            disp_valid <= 1'b1;
            ack        <= 4'b0001 << win_id;
            cnt        <= '0;
            state      <= HOLD;
          end
        end
        default: begin
          // Pinned source is re-served back to back; dwell only applies in rotation.
          if (pin_en || cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
